rggen_apb_arbiter: RTL and testbench

Multi-requester APB master arbiter that shares one generated register block's APB slave port among several on-chip requesters, e.g. a CPU bridge, a debug port and a DMA-based configuration loader. It accepts word-granular register access requests and grants one at a time in round-robin order. It drives a single APB3/APB4 transfer per grant, returns read data and error status to the granted requester, and terminates stalled transfers with a timeout.

---
 rtl/rggen_apb_arbiter_pkg.sv | 20 ++
 rtl/rggen_round_robin_arbiter.sv | 48 ++++
 rtl/rggen_apb_arbiter.sv | 145 ++++++++++++++
 tb/tb_rggen_apb_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rggen_apb_arbiter_pkg.sv
// Shared types and width helpers for the multi-requester APB arbiter.
package rggen_apb_arbiter_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE   = 2'd0;
   localparam state_t SETUP  = 2'd1;
   localparam state_t ACCESS = 2'd2;

   // Bits needed to hold a requester number; never narrower than one bit.
   function automatic int indexWidth(input int count);
      return (count > 1) ? $clog2(count) : 1;
   endfunction

   // Bits needed to count ACCESS cycles 0..cycles-1; never narrower than one bit.
   function automatic int counterWidth(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/rggen_round_robin_arbiter.sv
// Round-robin picker: searches upward from the requester after the last winner
// and owns the last-grant pointer, which only moves when a grant is taken.
module rggen_round_robin_arbiter
   import rggen_apb_arbiter_pkg::*;
#(
   parameter int REQUESTERS  = 2,
   parameter int INDEX_WIDTH = indexWidth(REQUESTERS)
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [REQUESTERS-1:0]  i_request,
   input  logic                   i_grant_enable,
   output logic [REQUESTERS-1:0]  o_grant,
   output logic [INDEX_WIDTH-1:0] o_index
);

   logic [INDEX_WIDTH-1:0] lastGrant_q;
   logic [INDEX_WIDTH-1:0] lastGrant_d;

   // Walk the requesters starting just past the last winner, wrapping at the top.
   always_comb begin
      logic                   found;
      logic [INDEX_WIDTH-1:0] candidate;
      found       = 1'b0;
      candidate   = '0;
      o_grant     = '0;
      o_index     = '0;
      for (int offset = 1; offset <= REQUESTERS; offset++) begin
         candidate = INDEX_WIDTH'((int'(lastGrant_q) + offset) % REQUESTERS);
         if (!found && i_request[candidate]) begin
            found              = 1'b1;
            o_grant[candidate] = i_grant_enable;
            o_index            = candidate;
         end
      end
      lastGrant_d = (i_grant_enable && found) ? o_index : lastGrant_q;
   end

   // Pointer starts at the top requester so requester 0 wins first after reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         lastGrant_q <= INDEX_WIDTH'(REQUESTERS - 1);
      end else begin
         lastGrant_q <= lastGrant_d;
      end
   end

endmodule

// File: rtl/rggen_apb_arbiter.sv
// Shares one APB slave port among several requesters: one transfer per grant,
// response routed back to the winner, stalled transfers ended by a timeout.
module rggen_apb_arbiter
   import rggen_apb_arbiter_pkg::*;
#(
   parameter int REQUESTERS     = 2,
   parameter int ADDRESS_WIDTH  = 7,
   parameter int BUS_WIDTH      = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                                      i_clk,
   input  logic                                      i_rst,
   input  logic [REQUESTERS-1:0]                     i_request,
   input  logic [REQUESTERS-1:0]                     i_write,
   input  logic [REQUESTERS-1:0][ADDRESS_WIDTH-1:0]  i_address,
   input  logic [REQUESTERS-1:0][BUS_WIDTH-1:0]      i_write_data,
   input  logic [REQUESTERS-1:0][BUS_WIDTH/8-1:0]    i_strobe,
   output logic [REQUESTERS-1:0]                     o_ack,
   output logic [BUS_WIDTH-1:0]                      o_read_data,
   output logic                                      o_error,
   output logic                                      o_psel,
   output logic                                      o_penable,
   output logic                                      o_pwrite,
   output logic [ADDRESS_WIDTH-1:0]                  o_paddr,
   output logic [BUS_WIDTH-1:0]                      o_pwdata,
   output logic [BUS_WIDTH/8-1:0]                    o_pstrb,
   input  logic                                      i_pready,
   input  logic                                      i_pslverr,
   input  logic [BUS_WIDTH-1:0]                      i_prdata
);

   localparam int STRB_WIDTH      = BUS_WIDTH / 8;
   localparam int INDEX_WIDTH     = indexWidth(REQUESTERS);
   localparam int COUNT_WIDTH     = counterWidth(TIMEOUT_CYCLES);
   localparam bit TIMEOUT_ENABLED = (TIMEOUT_CYCLES != 0);
   localparam logic [COUNT_WIDTH-1:0] COUNT_LAST =
      COUNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   state_t                   state_q,    state_d;
   logic [INDEX_WIDTH-1:0]   grantIdx_q, grantIdx_d;
   logic [ADDRESS_WIDTH-1:0] paddr_q,    paddr_d;
   logic                     pwrite_q,   pwrite_d;
   logic [BUS_WIDTH-1:0]     pwdata_q,   pwdata_d;
   logic [STRB_WIDTH-1:0]    pstrb_q,    pstrb_d;
   logic [COUNT_WIDTH-1:0]   count_q,    count_d;

   logic [REQUESTERS-1:0]    grant;
   logic [INDEX_WIDTH-1:0]   grantIndex;
   logic                     granted;
   logic                     timeoutHit;
   logic                     complete;
   logic                     ackFire;

   rggen_round_robin_arbiter #(
      .REQUESTERS  (REQUESTERS),
      .INDEX_WIDTH (INDEX_WIDTH)
   ) u_arbiter (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_request      (i_request),
      .i_grant_enable (state_q == IDLE),
      .o_grant        (grant),
      .o_index        (grantIndex)
   );

   assign granted    = |grant;
   assign timeoutHit = TIMEOUT_ENABLED && (state_q == ACCESS) && !i_pready && (count_q == COUNT_LAST);
   assign complete   = (state_q == ACCESS) && (i_pready || timeoutHit);
   assign ackFire    = complete && !i_rst;

   // Transfer sequencing: latch the winner's payload in IDLE, then SETUP, then ACCESS until done.
   always_comb begin
      state_d    = state_q;
      grantIdx_d = grantIdx_q;
      paddr_d    = paddr_q;
      pwrite_d   = pwrite_q;
      pwdata_d   = pwdata_q;
      pstrb_d    = pstrb_q;
      count_d    = count_q;
      case (state_q)
         IDLE: begin
            if (granted) begin
               state_d    = SETUP;
               grantIdx_d = grantIndex;
               paddr_d    = i_address[grantIndex];
               pwrite_d   = i_write[grantIndex];
               pwdata_d   = i_write_data[grantIndex];
               pstrb_d    = i_write[grantIndex] ? i_strobe[grantIndex] : '0;
            end
         end
         SETUP: begin
            state_d = ACCESS;
            count_d = '0;
         end
         ACCESS: begin
            count_d = count_q + COUNT_WIDTH'(1);
            if (complete) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, payload and timeout registers; reset drops any transfer without acking it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         grantIdx_q <= '0;
         paddr_q    <= '0;
         pwrite_q   <= 1'b0;
         pwdata_q   <= '0;
         pstrb_q    <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         grantIdx_q <= grantIdx_d;
         paddr_q    <= paddr_d;
         pwrite_q   <= pwrite_d;
         pwdata_q   <= pwdata_d;
         pstrb_q    <= pstrb_d;
         count_q    <= count_d;
      end
   end

   // Response fan-out: only the granted requester sees the completion pulse.
   always_comb begin
      o_ack = '0;
      if (ackFire) begin
         o_ack[grantIdx_q] = 1'b1;
      end
   end

   assign o_read_data = (ackFire && i_pready) ? i_prdata : '0;
   assign o_error     = ackFire && (i_pready ? i_pslverr : 1'b1);
   assign o_psel      = (state_q != IDLE);
   assign o_penable   = (state_q == ACCESS);
   assign o_pwrite    = pwrite_q;
   assign o_paddr     = paddr_q;
   assign o_pwdata    = pwdata_q;
   assign o_pstrb     = pstrb_q;

endmodule

// File: tb/tb_rggen_apb_arbiter.sv
// Self-checking bench for rggen_apb_arbiter: directed scenarios followed by
// randomized requester/slave traffic checked against a transaction-level model.
module tb_rggen_apb_arbiter;

   localparam int N   = 2;
   localparam int AW  = 7;
   localparam int BW  = 32;
   localparam int SW  = BW / 8;
   localparam int TMO = 4;

   logic                     i_clk = 1'b0;
   logic                     i_rst;
   logic [N-1:0]             i_request;
   logic [N-1:0]             i_write;
   logic [N-1:0][AW-1:0]     i_address;
   logic [N-1:0][BW-1:0]     i_write_data;
   logic [N-1:0][SW-1:0]     i_strobe;
   logic [N-1:0]             o_ack;
   logic [BW-1:0]            o_read_data;
   logic                     o_error;
   logic                     o_psel;
   logic                     o_penable;
   logic                     o_pwrite;
   logic [AW-1:0]            o_paddr;
   logic [BW-1:0]            o_pwdata;
   logic [SW-1:0]            o_pstrb;
   logic                     i_pready;
   logic                     i_pslverr;
   logic [BW-1:0]            i_prdata;

   // Requester-side model: pending accesses and the round-robin last winner.
   bit                       pending[N];
   bit                       wrQ[N];
   logic [AW-1:0]            addrQ[N];
   logic [BW-1:0]            dataQ[N];
   logic [SW-1:0]            strbQ[N];
   int                       lastGrant;

   int                       vectorCount = 0;
   int                       missCount   = 0;

   rggen_apb_arbiter #(
      .REQUESTERS     (N),
      .ADDRESS_WIDTH  (AW),
      .BUS_WIDTH      (BW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_request    (i_request),
      .i_write      (i_write),
      .i_address    (i_address),
      .i_write_data (i_write_data),
      .i_strobe     (i_strobe),
      .o_ack        (o_ack),
      .o_read_data  (o_read_data),
      .o_error      (o_error),
      .o_psel       (o_psel),
      .o_penable    (o_penable),
      .o_pwrite     (o_pwrite),
      .o_paddr      (o_paddr),
      .o_pwdata     (o_pwdata),
      .o_pstrb      (o_pstrb),
      .i_pready     (i_pready),
      .i_pslverr    (i_pslverr),
      .i_prdata     (i_prdata)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 i_clk = ~i_clk;

   // Hard stop in case the flow ever stalls.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, want $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic int modelWinner();
      for (int i = 1; i <= N; i++) begin
         int c;
         c = (lastGrant + i) % N;
         if (pending[c]) return c;
      end
      return -1;
   endfunction

   task automatic driveRequests();
      for (int i = 0; i < N; i++) begin
         i_request[i]    = pending[i];
         i_write[i]      = wrQ[i];
         i_address[i]    = addrQ[i];
         i_write_data[i] = dataQ[i];
         i_strobe[i]     = strbQ[i];
      end
   endtask

   task automatic setAccess(input int r, input bit wr, input logic [AW-1:0] a,
                            input logic [BW-1:0] d, input logic [SW-1:0] s);
      pending[r] = 1'b1;
      wrQ[r]     = wr;
      addrQ[r]   = a;
      dataQ[r]   = d;
      strbQ[r]   = s;
   endtask

   task automatic randomAccess(input int r);
      logic [4:0] word;
      word = 5'($urandom_range(0, 31));
      setAccess(r, 1'($urandom_range(0, 1)), {word, 2'b00}, $urandom, SW'($urandom_range(0, 15)));
   endtask

   // Holds reset over two edges, checks the idle outputs, then releases it.
   task automatic resetDut();
      i_rst = 1'b1;
      for (int i = 0; i < N; i++) pending[i] = 1'b0;
      driveRequests();
      i_pready  = 1'b0;
      i_pslverr = 1'b0;
      i_prdata  = '0;
      @(negedge i_clk);
      @(negedge i_clk);
      #1;
      checkOutput("rst_psel",    o_psel,      0);
      checkOutput("rst_penable", o_penable,   0);
      checkOutput("rst_pwrite",  o_pwrite,    0);
      checkOutput("rst_paddr",   o_paddr,     0);
      checkOutput("rst_pwdata",  o_pwdata,    0);
      checkOutput("rst_pstrb",   o_pstrb,     0);
      checkOutput("rst_ack",     o_ack,       0);
      checkOutput("rst_rdata",   o_read_data, 0);
      checkOutput("rst_error",   o_error,     0);
      @(negedge i_clk);
      i_rst     = 1'b0;
      lastGrant = N - 1;
   endtask

   // One full transfer from an IDLE cycle with at least one pending requester.
   // The slave raises pready after 'waits' ACCESS cycles; waits >= TMO forces a timeout.
   task automatic applyStimulus(input int waits, input bit slaveErr, input logic [BW-1:0] rdataVal);
      int winner;
      bit ackSeen;
      winner = modelWinner();
      checkOutput("idle_psel", o_psel, 0);
      checkOutput("idle_ack",  o_ack,  0);
      @(negedge i_clk);
      #1;
      checkOutput("setup_psel",    o_psel,    1);
      checkOutput("setup_penable", o_penable, 0);
      checkOutput("setup_ack",     o_ack,     0);
      checkOutput("setup_paddr",   o_paddr,   addrQ[winner]);
      checkOutput("setup_pwrite",  o_pwrite,  wrQ[winner]);
      checkOutput("setup_pwdata",  o_pwdata,  dataQ[winner]);
      checkOutput("setup_pstrb",   o_pstrb,   wrQ[winner] ? strbQ[winner] : '0);
      ackSeen = 1'b0;
      for (int k = 0; k < TMO + 2 && !ackSeen; k++) begin
         @(negedge i_clk);
         i_pready  = (k == waits);
         i_pslverr = slaveErr && (k == waits);
         i_prdata  = (k == waits) ? rdataVal : BW'($urandom);
         #1;
         checkOutput("acc_psel",    o_psel,    1);
         checkOutput("acc_penable", o_penable, 1);
         checkOutput("acc_paddr",   o_paddr,   addrQ[winner]);
         checkOutput("acc_pwdata",  o_pwdata,  dataQ[winner]);
         checkOutput("acc_pstrb",   o_pstrb,   wrQ[winner] ? strbQ[winner] : '0);
         if (k == waits || k == TMO - 1) begin
            ackSeen = 1'b1;
            checkOutput("ack", o_ack, 64'(1) << winner);
            if (k == waits) begin
               checkOutput("ack_rdata", o_read_data, rdataVal);
               checkOutput("ack_error", o_error,     slaveErr);
            end else begin
               checkOutput("tmo_rdata", o_read_data, 0);
               checkOutput("tmo_error", o_error,     1);
            end
            lastGrant       = winner;
            pending[winner] = 1'b0;
            driveRequests();
         end else begin
            checkOutput("wait_ack",   o_ack,       0);
            checkOutput("wait_rdata", o_read_data, 0);
            checkOutput("wait_error", o_error,     0);
         end
      end
      if (!ackSeen) checkOutput("ack_bound", 0, 1);
      @(negedge i_clk);
      i_pready  = 1'b0;
      i_pslverr = 1'b0;
      i_prdata  = '0;
      #1;
      checkOutput("post_psel", o_psel, 0);
      checkOutput("post_ack",  o_ack,  0);
   endtask

   initial begin
      for (int i = 0; i < N; i++) setAccess(i, 1'b0, '0, '0, '0);
      resetDut();

      // Single read from requester 0 with zero wait states.
      setAccess(0, 1'b0, 7'h04, 32'hDEADBEEF, 4'hF);
      driveRequests();
      #1;
      applyStimulus(0, 1'b0, 32'h000000A5);

      // Both requesters always requesting: grants must alternate starting at 0.
      resetDut();
      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < N; i++) if (!pending[i]) randomAccess(i);
         driveRequests();
         #1;
         checkOutput("rr_order", modelWinner(), t % 2);
         applyStimulus(int'($urandom_range(0, 2)), 1'b0, $urandom);
      end

      // Write with three wait states ending in a slave error.
      for (int i = 0; i < N; i++) pending[i] = 1'b0;
      setAccess(1, 1'b1, 7'h10, 32'h12345678, 4'hF);
      driveRequests();
      #1;
      applyStimulus(3, 1'b1, $urandom);

      // Slave never answers: forced completion in the last allowed ACCESS cycle.
      setAccess(0, 1'b0, 7'h20, 32'h0, 4'h0);
      driveRequests();
      #1;
      applyStimulus(100, 1'b0, '0);

      // Reset during a wait state: no ack, bus released, pointer back to start.
      setAccess(0, 1'b1, 7'h0C, 32'hCAFEF00D, 4'h3);
      pending[1] = 1'b0;
      driveRequests();
      @(negedge i_clk);
      @(negedge i_clk);
      i_pready = 1'b0;
      #1;
      checkOutput("mid_penable", o_penable, 1);
      @(negedge i_clk);
      i_rst = 1'b1;
      #1;
      checkOutput("mid_rst_ack", o_ack, 0);
      @(negedge i_clk);
      #1;
      checkOutput("after_rst_psel",    o_psel,    0);
      checkOutput("after_rst_penable", o_penable, 0);
      checkOutput("after_rst_ack",     o_ack,     0);
      i_rst     = 1'b0;
      lastGrant = N - 1;
      setAccess(0, 1'b0, 7'h08, 32'h0, 4'h0);
      setAccess(1, 1'b0, 7'h18, 32'h0, 4'h0);
      driveRequests();
      #1;
      checkOutput("rst_first_winner", modelWinner(), 0);
      applyStimulus(0, 1'b0, $urandom);

      // Randomized traffic: requesters raise new accesses at random while idle.
      for (int t = 0; t < 80; t++) begin
         bit any;
         any = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (!pending[i] && ($urandom_range(0, 2) != 0)) randomAccess(i);
            any |= pending[i];
         end
         driveRequests();
         #1;
         if (any) begin
            applyStimulus(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), $urandom);
         end else begin
            checkOutput("idle_hold_psel", o_psel, 0);
            @(negedge i_clk);
            #1;
            checkOutput("idle_stay_psel", o_psel, 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
